// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter among NUM_REQ byte streams.
// One tx_start per accepted byte; the next byte waits for the full tx_busy cycle.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic [2:0]             grant_id,
    output logic                   grant_active,
    output logic                   tx_timeout
);

    // state   | meaning
    // IDLE    | no packet owner; arbitrate when a request is present and UART is idle
    // SEND    | one-cycle tx_start / req_ready pulse for the loaded byte
    // WAIT_HI | waiting for tx_busy to rise (bounded by BUSY_TIMEOUT)
    // WAIT_LO | waiting for tx_busy to fall
    // NEXT    | packet locked to grant_id; waiting for its next byte
    typedef enum logic [2:0] {IDLE, SEND, WAIT_HI, WAIT_LO, NEXT} state_t;

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    state_t             state;
    state_t             state_next;
    logic [2:0]         last_grant;
    logic               last_flag;
    logic [CNT_W-1:0]   busy_cnt;

    logic [NUM_REQ-1:0] rot;
    logic [2:0]         rr_win;
    logic               rr_found;
    int                 sum;
    logic [2:0]         sel_idx;
    logic [7:0]         sel_data;
    logic               sel_last;
    logic               sel_valid;
    logic               load;
    logic               arb_win;
    logic               timeout_hit;
    logic               pkt_done;

    // Rotate so bit 0 is the requester right after last_grant; lowest set bit wins.
    always_comb begin
        rot      = NUM_REQ'({req_valid, req_valid} >> (last_grant + 3'd1));
        rr_found = 1'b0;
        rr_win   = '0;
        sum      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = int'(last_grant) + 1 + k;
                if (sum >= NUM_REQ) sum = sum - NUM_REQ;
                rr_found = 1'b1;
                rr_win   = 3'(sum);
            end
        end
    end

    always_comb begin
        sel_idx   = (state == IDLE) ? rr_win : grant_id;
        sel_data  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == 3'(i)) begin
                sel_data  = req_data[8*i +: 8];
                sel_last  = req_last[i];
                sel_valid = req_valid[i];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state == SEND) && (grant_id == 3'(i));
        end
    end

    always_comb begin
        state_next  = state;
        load        = 1'b0;
        arb_win     = 1'b0;
        timeout_hit = 1'b0;
        pkt_done    = 1'b0;
        case (state)
            IDLE: begin
                if (rr_found && !tx_busy) begin
                    state_next = SEND;
                    load       = 1'b1;
                    arb_win    = 1'b1;
                end
            end
            SEND: state_next = WAIT_HI;
            WAIT_HI: begin
                if (tx_busy) begin
                    state_next = WAIT_LO;
                end else if (busy_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (last_flag) begin
                        state_next = IDLE;
                        pkt_done   = 1'b1;
                    end else begin
                        state_next = NEXT;
                    end
                end
            end
            NEXT: begin
                if (sel_valid && !tx_busy) begin
                    state_next = SEND;
                    load       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data      <= '0;
            tx_start     <= 1'b0;
            tx_timeout   <= 1'b0;
            grant_id     <= '0;
            grant_active <= 1'b0;
            last_grant   <= 3'(NUM_REQ - 1);
            last_flag    <= 1'b0;
            busy_cnt     <= '0;
        end else begin
            tx_start   <= (state_next == SEND);
            tx_timeout <= timeout_hit;
            if (load) begin
                tx_data   <= sel_data;
                last_flag <= sel_last;
            end
            if (arb_win) begin
                grant_id     <= rr_win;
                grant_active <= 1'b1;
            end
            if (pkt_done) begin
                grant_active <= 1'b0;
                last_grant   <= grant_id;
            end
            if (state == SEND) begin
                busy_cnt <= '0;
            end else if (state == WAIT_HI && !tx_busy) begin
                busy_cnt <= busy_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: random requesters and a UART busy responder, checked every cycle
// against a transaction-level model, plus directed scenarios with literal expectations.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int BT = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     vld;
    logic [8*N-1:0]   dat;
    logic [N-1:0]     lst;
    logic [N-1:0]     req_ready;
    logic [7:0]       tx_data;
    logic             tx_start;
    logic             tx_busy;
    logic [2:0]       grant_id;
    logic             grant_active;
    logic             tx_timeout;

    uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(vld), .req_data(dat), .req_last(lst), .req_ready(req_ready),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .grant_id(grant_id), .grant_active(grant_active), .tx_timeout(tx_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Byte streams: q is consumed by the requester driver, mq by the model.
    logic [8:0] q  [N][$];
    logic [8:0] mq [N][$];
    bit         gate [N];
    bit         respond_en = 1'b1;
    bit         noise_en   = 1'b0;

    logic [7:0] byte_log[$];
    int         id_log[$];
    logic [N-1:0] rdy_log[$];
    int         st_cyc[$];
    int         to_cyc[$];
    int         vrise[N];
    logic [N-1:0] prev_v = '0;

    // Model: who owns the transmitter and where the current byte is in its busy handshake.
    bit         e_start, e_timeout, e_active;
    logic [7:0] e_data;
    logic [2:0] e_gid;
    logic [N-1:0] e_ready;
    int         m_owner, m_lastg, m_wcnt;
    bit         m_open, m_seen, m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {14'b0, tx_start, tx_timeout, grant_active, grant_id, req_ready, tx_data};
    endfunction

    function automatic logic [31:0] exp_outs();
        return {14'b0, e_start, e_timeout, e_active, e_gid, e_ready, e_data};
    endfunction

    task automatic model_reset();
        e_start = 0; e_timeout = 0; e_active = 0; e_data = '0; e_gid = '0; e_ready = '0;
        m_owner = -1; m_lastg = N - 1; m_wcnt = 0; m_open = 0; m_seen = 0; m_last = 0;
    endtask

    task automatic model_step(input logic [N-1:0] v, input logic b);
        bit ns;
        bit nt;
        int c;
        ns = 0;
        nt = 0;
        if (e_start) begin
            m_open = 1; m_seen = 0; m_wcnt = 0;
        end else if (m_open && !m_seen) begin
            if (b) m_seen = 1;
            else if (m_wcnt == BT - 1) begin nt = 1; m_seen = 1; end
            else m_wcnt++;
        end else if (m_open) begin
            if (!b) begin
                m_open = 0;
                if (m_last) begin m_owner = -1; m_lastg = int'(e_gid); end
            end
        end else if (!b) begin
            if (m_owner < 0) begin
                for (int k = 1; k <= N; k++) begin
                    c = (m_lastg + k) % N;
                    if (m_owner < 0 && v[c]) begin m_owner = c; e_gid = 3'(c); end
                end
            end
            if (m_owner >= 0 && v[m_owner]) begin
                ns = 1;
                if (mq[m_owner].size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL model_queue: requester %0d valid with nothing queued", m_owner);
                end else begin
                    {m_last, e_data} = mq[m_owner].pop_front();
                end
            end
        end
        e_start   = ns;
        e_timeout = nt;
        e_active  = (m_owner >= 0);
        e_ready   = '0;
        if (ns) e_ready[e_gid] = 1'b1;
    endtask

    initial begin : model
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            chk($sformatf("cycle %0d outputs", cyc), outs(), exp_outs());
            if (rst_n) model_step(vld, tx_busy);
            if (tx_start) begin
                byte_log.push_back(tx_data);
                id_log.push_back(int'(grant_id));
                rdy_log.push_back(req_ready);
                st_cyc.push_back(cyc);
            end
            if (tx_timeout) to_cyc.push_back(cyc);
            for (int i = 0; i < N; i++) if (vld[i] && !prev_v[i]) vrise[i] = cyc;
            prev_v = vld;
        end
    end

    initial begin : requesters
        logic [N-1:0] rs;
        vld = '0; dat = '0; lst = '0;
        forever begin
            @(negedge clk);
            rs = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (rs[i] && q[i].size() > 0) begin
                    void'(q[i].pop_front());
                    vld[i] = 1'b0;
                end
                if (!vld[i] && q[i].size() > 0 && gate[i]) vld[i] = 1'b1;
                if (vld[i]) begin
                    dat[8*i +: 8] = q[i][0][7:0];
                    lst[i]        = q[i][0][8];
                end else begin
                    dat[8*i +: 8] = 8'($urandom);
                    lst[i]        = 1'($urandom);
                end
            end
        end
    end

    initial begin : uart
        int pd, pl, len;
        bit pend;
        tx_busy = 1'b0; pd = 0; pl = 0; len = 0; pend = 0;
        forever begin
            @(negedge clk);
            if (tx_start && respond_en && rst_n) begin
                pend = 1;
                pd = int'($urandom_range(0, 2));
                pl = int'($urandom_range(1, 5));
            end
            @(posedge clk);
            #1;
            if (len > 0) begin tx_busy = 1'b1; len--; end
            else if (pend && pd == 0) begin pend = 0; tx_busy = 1'b1; len = pl - 1; end
            else if (pend) begin pd--; tx_busy = 1'b0; end
            else if (noise_en && $urandom_range(0, 15) == 0) begin
                tx_busy = 1'b1; len = int'($urandom_range(0, 2));
            end
            else tx_busy = 1'b0;
        end
    end

    task automatic push_byte(input int r, input logic [7:0] d, input logic l);
        q[r].push_back({l, d});
        mq[r].push_back({l, d});
    endtask

    task automatic enq_pkt(input int r, input int len);
        for (int j = 0; j < len; j++) push_byte(r, 8'($urandom), j == len - 1);
    endtask

    task automatic clear_logs();
        byte_log.delete(); id_log.delete(); rdy_log.delete(); st_cyc.delete(); to_cyc.delete();
    endtask

    task automatic set_gates(input bit g);
        for (int r = 0; r < N; r++) gate[r] = g;
    endtask

    task automatic wait_starts(input int n, input string name);
        int b;
        b = 0;
        while (byte_log.size() < n && b < 3000) begin @(posedge clk); b++; end
        if (byte_log.size() < n) chk(name, byte_log.size(), n);
    endtask

    task automatic drain();
        int b;
        int rem;
        b = 0;
        respond_en = 1; noise_en = 0; set_gates(1);
        do begin
            @(posedge clk);
            b++;
            rem = int'(grant_active) + int'(m_open);
            for (int r = 0; r < N; r++) rem += q[r].size() + mq[r].size();
        end while (rem != 0 && b < 5000);
        chk("drain_remaining", rem, 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] exp_rr [5];
        logic [7:0] exp_pk [4];
        int b;
        exp_rr = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h30};
        exp_pk = '{8'h41, 8'h42, 8'h43, 8'h58};
        set_gates(0);

        // Reset values, then round robin straight out of reset.
        for (int r = 0; r < N; r++) begin
            push_byte(r, 8'(8'h30 + r), 1'b1);
            push_byte(r, 8'(8'h30 + r), 1'b1);
        end
        set_gates(1);
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs", outs(), 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        wait_starts(5, "rr_starts");
        for (int k = 0; k < 5; k++) chk($sformatf("rr_byte%0d", k), byte_log[k], exp_rr[k]);
        drain();

        // Single one-byte packet from requester 2.
        set_gates(0);
        clear_logs();
        push_byte(2, 8'h41, 1'b1);
        gate[2] = 1;
        wait_starts(1, "single_starts");
        chk("single_data", byte_log[0], 8'h41);
        chk("single_grant_id", id_log[0], 2);
        chk("single_ready", rdy_log[0], 4'b0100);
        chk("single_latency", st_cyc[0] - vrise[2], 1);
        drain();

        // Packet lock with a 50-cycle stall after the first byte; requester 1 waits.
        set_gates(0);
        clear_logs();
        push_byte(0, 8'h41, 1'b0);
        push_byte(0, 8'h42, 1'b0);
        push_byte(0, 8'h43, 1'b1);
        push_byte(1, 8'h58, 1'b1);
        gate[0] = 1;
        wait_starts(1, "lock_first");
        gate[0] = 0;
        gate[1] = 1;
        repeat (50) @(posedge clk);
        chk("stall_grant_id", grant_id, 3'd0);
        chk("stall_starts", byte_log.size(), 1);
        gate[0] = 1;
        wait_starts(4, "lock_starts");
        for (int k = 0; k < 4; k++) chk($sformatf("lock_byte%0d", k), byte_log[k], exp_pk[k]);
        chk("lock_last_id", id_log[3], 1);
        drain();

        // Busy never rises: each byte times out, then the packet continues.
        set_gates(0);
        clear_logs();
        respond_en = 0;
        push_byte(3, 8'h55, 1'b0);
        push_byte(3, 8'h56, 1'b1);
        gate[3] = 1;
        b = 0;
        while (to_cyc.size() < 2 && b < 300) begin @(posedge clk); b++; end
        chk("timeout_count", to_cyc.size(), 2);
        chk("timeout_delay0", to_cyc[0] - st_cyc[0], BT + 1);
        chk("timeout_delay1", to_cyc[1] - st_cyc[1], BT + 1);
        chk("timeout_byte1", byte_log[1], 8'h56);
        drain();

        // Random traffic, busy noise and occasional unresponsive UART.
        for (int it = 0; it < 60; it++) begin
            for (int r = 0; r < N; r++)
                if ($urandom_range(0, 2) == 0 && q[r].size() < 6) enq_pkt(r, int'($urandom_range(1, 4)));
            respond_en = ($urandom_range(0, 9) != 0);
            noise_en   = 1'($urandom_range(0, 1));
            repeat ($urandom_range(20, 60)) begin
                @(posedge clk);
                for (int r = 0; r < N; r++) gate[r] = ($urandom_range(0, 3) != 0);
            end
        end
        drain();

        // Reset while a byte is waiting for busy to fall.
        for (int r = 0; r < N; r++) begin enq_pkt(r, 3); enq_pkt(r, 3); end
        set_gates(1);
        respond_en = 1; noise_en = 0;
        b = 0;
        do begin @(posedge clk); #2; b++; end while (!(m_open && m_seen) && b < 2000);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", outs(), 32'h0);
        clear_logs();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        wait_starts(1, "after_reset_starts");
        chk("first_grant_after_reset", id_log[0], 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
